// File: rtl/xtal_clk_supervisor_pkg.sv
// Shared definitions for the crystal oscillator supervisor: state encoding
// and default timing constants.
package xtal_clk_supervisor_pkg;

    localparam logic [1:0] ST_OFF     = 2'd0;
    localparam logic [1:0] ST_STARTUP = 2'd1;
    localparam logic [1:0] ST_RUNNING = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    typedef enum logic [1:0] {
        S_OFF     = ST_OFF,
        S_STARTUP = ST_STARTUP,
        S_RUNNING = ST_RUNNING,
        S_FAULT   = ST_FAULT
    } xcs_state_e;

    localparam int DEF_STARTUP_EDGES = 1024;
    localparam int DEF_GAP_TIMEOUT   = 64;
    localparam int DEF_START_TIMEOUT = 65535;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/xtal_clk_supervisor_edge_sync.sv
// Brings the raw oscillator clock into the reference domain and emits a
// one-cycle pulse per rising edge of the synchronized value.
module xclk_edge_sync
    import xtal_clk_supervisor_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic xclk_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= xclk_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Only an exact 1-after-0 pattern fires; unknown values fall to the default.
    always_comb begin
        pulse_o = 1'b0;
        case ({sync2_q, prev_q})
            2'b10:   pulse_o = 1'b1;
            default: pulse_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/xtal_clk_supervisor.sv
// Crystal oscillator supervisor: enables the oscillator, counts startup edges,
// raises READY once stable and a sticky FAULT on startup timeout or clock loss.
module xtal_clk_supervisor
    import xtal_clk_supervisor_pkg::*;
#(
    parameter int STARTUP_EDGES = DEF_STARTUP_EDGES,
    parameter int GAP_TIMEOUT   = DEF_GAP_TIMEOUT,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             CLR_FAULT,
    input  logic             XCLK,
    output logic             XTAL_EN,
    output logic             READY,
    output logic             FAULT,
    output logic [CNT_W-1:0] EDGE_CNT
);

    localparam logic [CNT_W-1:0] EDGES_MAX = CNT_W'(STARTUP_EDGES);
    localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(GAP_TIMEOUT);
    localparam logic [CNT_W-1:0] START_MAX = CNT_W'(START_TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

    logic             edge_pulse;
    xcs_state_e       state_q, state_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] start_tmr_q, start_tmr_d;
    logic [CNT_W-1:0] gap_tmr_q, gap_tmr_d;
    logic             xtal_en_q, xtal_en_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    xclk_edge_sync u_edge_sync (
        .clk_i   (CLK),
        .rst_i   (RST),
        .xclk_i  (XCLK),
        .pulse_o (edge_pulse)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_OFF;
            edge_cnt_q  <= '0;
            start_tmr_q <= '0;
            gap_tmr_q   <= '0;
            xtal_en_q   <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            start_tmr_q <= start_tmr_d;
            gap_tmr_q   <= gap_tmr_d;
            xtal_en_q   <= xtal_en_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        start_tmr_d = start_tmr_q;
        gap_tmr_d   = gap_tmr_q;

        case (state_q)
            S_OFF: begin
                if (ENABLE) begin
                    state_d     = S_STARTUP;
                    edge_cnt_d  = '0;
                    start_tmr_d = '0;
                    gap_tmr_d   = '0;
                end
            end
            S_STARTUP: begin
                start_tmr_d = sat_inc(start_tmr_q, START_MAX);
                gap_tmr_d   = '0;
                if (edge_pulse) begin
                    edge_cnt_d = sat_inc(edge_cnt_q, EDGES_MAX);
                end
                // Disable beats everything; a completed edge count beats the timeout.
                if (!ENABLE) begin
                    state_d = S_OFF;
                end else if (edge_cnt_d >= EDGES_MAX) begin
                    state_d = S_RUNNING;
                end else if (start_tmr_d >= START_MAX) begin
                    state_d = S_FAULT;
                end
            end
            S_RUNNING: begin
                gap_tmr_d = edge_pulse ? '0 : sat_inc(gap_tmr_q, GAP_MAX);
                if (!ENABLE) begin
                    state_d = S_OFF;
                end else if (gap_tmr_d >= GAP_MAX) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (CLR_FAULT) begin
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Outputs follow the next state so they change on the same edge as the state.
        xtal_en_d = (state_d == S_STARTUP) || (state_d == S_RUNNING);
        ready_d   = (state_d == S_RUNNING);
        fault_d   = (state_d == S_FAULT);
    end

    assign XTAL_EN  = xtal_en_q;
    assign READY    = ready_q;
    assign FAULT    = fault_q;
    assign EDGE_CNT = edge_cnt_q;

endmodule

// File: doc/xtal_clk_supervisor.md
Name: xtal_clk_supervisor

Overview:
- Sits directly downstream of the crystal oscillator macro.
- Drives the oscillator's enable and watches its raw CLK output, which enters this block as asynchronous input XCLK.
- Counts xtal edges during startup, declares the clock ready, and flags a fault if the oscillator stops toggling.
- READY drives the system clock-mux select. The block runs on the always-on reference clock.

Parameters:
- STARTUP_EDGES, 1024: rising XCLK edges required in STARTUP before READY asserts.
- GAP_TIMEOUT, 64: CLK cycles without an XCLK rising edge in RUNNING that cause a fault.
- START_TIMEOUT, 65535: max CLK cycles spent in STARTUP before a fault.
- CNT_W, 16: counter width; must hold max(STARTUP_EDGES, START_TIMEOUT, GAP_TIMEOUT).

Ports:
- CLK  in  1  reference clock (always running).
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  software request to run the crystal.
- CLR_FAULT  in  1  single-cycle pulse; clears FAULT.
- XCLK  in  1  raw oscillator clock, asynchronous to CLK.
- XTAL_EN  out  1  enable to the oscillator macro.
- READY  out  1  crystal clock stable; clock-mux select.
- FAULT  out  1  startup timeout or clock loss, sticky.
- EDGE_CNT  out  CNT_W  current STARTUP edge count, for debug.

Behaviour:
- Reset and clocking:
  - One clock, CLK. Reset is asynchronous, active-high on RST.
  - On reset: state=OFF; XTAL_EN=0, READY=0, FAULT=0, EDGE_CNT=0; all counters 0.
  - All outputs are registered.
- Edge detection:
  - XCLK passes through a 2-flop synchronizer, then a rising-edge detector (sync2 high, prev low).
  - A pulse appears 2-3 CLK cycles after the XCLK rise.
  - Only a clean 0->1 of the synchronized value counts; X or Z never produces a pulse.
  - The requirement is f(CLK) >= 3*f(XCLK); the edge count is exact under this.
- State OFF:
  - XTAL_EN=0, READY=0.
  - ENABLE=1 -> STARTUP; EDGE_CNT, start timer and gap timer clear on entry.
- State STARTUP:
  - XTAL_EN=1. Start timer increments every cycle; EDGE_CNT increments on each edge pulse.
  - EDGE_CNT reaching STARTUP_EDGES -> RUNNING; READY=1 in the same cycle the state becomes RUNNING.
  - Start timer reaching START_TIMEOUT first -> FAULT.
  - Both in the same cycle -> RUNNING (edge count wins).
  - ENABLE=0 -> OFF; this takes priority over both.
- State RUNNING:
  - XTAL_EN=1, READY=1.
  - Gap timer clears on each edge pulse and increments otherwise. Reaching GAP_TIMEOUT -> FAULT.
  - ENABLE=0 -> OFF; priority over the gap timeout in the same cycle.
  - EDGE_CNT holds its final value.
- State FAULT:
  - FAULT=1, READY=0, XTAL_EN=0 (oscillator stopped).
  - ENABLE is ignored.
  - CLR_FAULT=1 -> OFF and FAULT clears. If ENABLE is still 1, STARTUP follows on the next cycle.
- CLR_FAULT outside FAULT: no effect.
- READY deasserts in the same cycle the state leaves RUNNING; no glitch, because it is registered.
- RST mid-operation: immediate return to reset values, including during STARTUP and RUNNING.
- Counters saturate, never wrap: the start timer at START_TIMEOUT, the gap timer at GAP_TIMEOUT, EDGE_CNT at STARTUP_EDGES.

Decomposition:
- Shared package holds:
  - State encoding localparams: OFF=2'd0, STARTUP=2'd1, RUNNING=2'd2, FAULT=2'd3.
  - Default parameter constants.
- One sub-module, xclk_edge_sync: 2-flop synchronizer plus rising-edge pulse, clocked by CLK with async RST.
- The FSM and counters live in the top level.

Test Plan:
Common bench settings: STARTUP_EDGES=8, GAP_TIMEOUT=16, START_TIMEOUT=200, CLK period 10ns, XCLK period 40ns.
1. Reset then idle: RST for 3 cycles, ENABLE=0 -> XTAL_EN=0, READY=0, FAULT=0, EDGE_CNT=0 indefinitely.
2. Nominal startup: ENABLE=1, XCLK toggles from 50ns -> XTAL_EN=1 next cycle; READY rises 2-3 cycles after the 8th XCLK rise; EDGE_CNT=8.
3. Startup timeout: ENABLE=1, XCLK held 0 -> FAULT=1 and XTAL_EN=0 exactly 200 cycles after STARTUP entry; READY never 1.
4. Clock loss: after READY, stop XCLK low -> FAULT=1 and READY=0 16 cycles after the last edge pulse. CLR_FAULT pulse with ENABLE=1 -> OFF, then STARTUP, then READY again after 8 edges.
5. Disable races timeout: in RUNNING, drop ENABLE in the same cycle the gap timer hits 16 -> state OFF, FAULT stays 0. Separately, drop ENABLE mid-STARTUP at EDGE_CNT=4 -> OFF, EDGE_CNT cleared on the next STARTUP.
6. Async reset mid-RUNNING: assert RST between CLK edges -> READY, XTAL_EN and FAULT go 0 immediately, without waiting for a CLK edge.
